// File: rtl/cmem_dbuf.sv
// rtl/cmem_dbuf.sv - double-buffered FIR coefficient memory with safe-point bank swap
module cmem_dbuf #(
   parameter int DATA_W = 16,
   parameter int TAPS   = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_start,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_full,
   input  logic              commit_req,
   output logic              commit_pend,
   output logic              commit_ack,
   output logic              commit_err,
   input  logic              swap_ok,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              active_bank
);

   localparam int MEM_AW = ADDR_W + 1;
   localparam int DEPTH  = 2 * TAPS;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_PEND} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] wptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_en;
   logic              wr_last;
   logic              do_swap;
   logic              err_nxt;
   logic              rd_oob;
   logic [MEM_AW-1:0] waddr;
   logic [MEM_AW-1:0] raddr;

   // ld_start overrides every other action, including a same-cycle data word or swap
   assign wr_en   = ld_ready && ld_valid && !ld_start;
   assign wr_last = wr_en && (wptr == ADDR_W'(TAPS - 1));
   assign do_swap = (state == S_PEND) && swap_ok && !ld_start;
   assign err_nxt = commit_req && ((state == S_IDLE) || (state == S_LOAD));

   // Bank b occupies words [b*TAPS, b*TAPS+TAPS); the shadow is always the inactive bank
   assign waddr  = (active_bank ? MEM_AW'(0) : MEM_AW'(TAPS)) + MEM_AW'(wptr);
   assign raddr  = (active_bank ? MEM_AW'(TAPS) : MEM_AW'(0)) + MEM_AW'(rd_addr);
   assign rd_oob = ({1'b0, rd_addr} >= MEM_AW'(TAPS));

   always_comb begin
      state_nxt = state;
      if (ld_start) begin
         state_nxt = S_LOAD;
      end else begin
         case (state)
            S_LOAD:  if (wr_last)    state_nxt = S_FULL;
            S_FULL:  if (commit_req) state_nxt = S_PEND;
            S_PEND:  if (swap_ok)    state_nxt = S_IDLE;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         wptr        <= '0;
         active_bank <= 1'b0;
         ld_ready    <= 1'b0;
         ld_full     <= 1'b0;
         commit_pend <= 1'b0;
         commit_ack  <= 1'b0;
         commit_err  <= 1'b0;
         rd_data     <= '0;
      end else begin
         state       <= state_nxt;
         ld_ready    <= (state_nxt == S_LOAD);
         ld_full     <= (state_nxt == S_FULL) || (state_nxt == S_PEND);
         commit_pend <= (state_nxt == S_PEND);
         commit_ack  <= do_swap;
         commit_err  <= err_nxt;
         active_bank <= active_bank ^ do_swap;
         if (ld_start || do_swap)
            wptr <= '0;
         else if (wr_en)
            wptr <= wptr + ADDR_W'(1);
         // Read uses the pre-edge bank, so a read in the swap cycle still sees the old set
         if (rd_en)
            rd_data <= rd_oob ? '0 : mem[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr_en)
         mem[waddr] <= ld_data;
   end

endmodule

// File: tb/tb_cmem_dbuf.sv
// tb/tb_cmem_dbuf.sv - directed self-checking bench for cmem_dbuf
module tb_cmem_dbuf;

   logic        clk = 1'b0;
   logic        rst_n;
   int          n_chk = 0;
   int          n_pass = 0;

   logic        ld_start, ld_valid, commit_req, swap_ok, rd_en;
   logic [15:0] ld_data;
   logic [5:0]  rd_addr;
   logic        ld_ready, ld_full, commit_pend, commit_ack, commit_err, active_bank;
   logic [15:0] rd_data;

   logic        b_ld_start, b_ld_valid, b_commit_req, b_swap_ok, b_rd_en;
   logic [15:0] b_ld_data;
   logic [5:0]  b_rd_addr;
   logic        b_ld_ready, b_ld_full, b_commit_pend, b_commit_ack, b_commit_err, b_active_bank;
   logic [15:0] b_rd_data;

   always #5 clk = ~clk;

   cmem_dbuf #(.DATA_W(16), .TAPS(64), .ADDR_W(6)) u_dut (
      .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid),
      .ld_ready(ld_ready), .ld_data(ld_data), .ld_full(ld_full),
      .commit_req(commit_req), .commit_pend(commit_pend), .commit_ack(commit_ack),
      .commit_err(commit_err), .swap_ok(swap_ok), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .active_bank(active_bank)
   );

   cmem_dbuf #(.DATA_W(16), .TAPS(40), .ADDR_W(6)) u_dut40 (
      .clk(clk), .rst_n(rst_n), .ld_start(b_ld_start), .ld_valid(b_ld_valid),
      .ld_ready(b_ld_ready), .ld_data(b_ld_data), .ld_full(b_ld_full),
      .commit_req(b_commit_req), .commit_pend(b_commit_pend), .commit_ack(b_commit_ack),
      .commit_err(b_commit_err), .swap_ok(b_swap_ok), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
      .rd_data(b_rd_data), .active_bank(b_active_bank)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_a();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic load_a(input logic [15:0] base, input int first, input int n);
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data  = base + 16'(first + i);
         tick();
      end
      ld_valid = 1'b0;
   endtask

   task automatic commit_swap_a();
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      swap_ok = 1'b1;
      tick();
      swap_ok = 1'b0;
   endtask

   task automatic read_a(input logic [5:0] addr);
      rd_en = 1'b1;
      rd_addr = addr;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic read_b(input logic [5:0] addr);
      b_rd_en = 1'b1;
      b_rd_addr = addr;
      tick();
      b_rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_chk++;
      if ({ld_ready, ld_full, commit_pend, commit_ack, commit_err, active_bank} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000",
                  {ld_ready, ld_full, commit_pend, commit_ack, commit_err, active_bank});
      else n_pass++;
      n_chk++;
      if (rd_data !== 16'h0) $display("FAIL reset_rd_data: got %h want 0000", rd_data);
      else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   // Fill both banks with known patterns so "old bank" reads are checkable
   task automatic test_preload();
      start_a();
      load_a(16'hA000, 0, 64);
      commit_swap_a();
      start_a();
      load_a(16'hB000, 0, 64);
      commit_swap_a();
      n_chk++;
      if (active_bank !== 1'b0) $display("FAIL preload_bank: got %b want 0", active_bank);
      else n_pass++;
   endtask

   task automatic test_load();
      int acc = 0;
      int low_k = -1;
      start_a();
      for (int k = 0; k < 70; k++) begin
         ld_valid = 1'b1;
         ld_data  = 16'(acc + 1);
         if (ld_ready) acc++;
         else if (low_k < 0) low_k = k;
         tick();
      end
      ld_valid = 1'b0;
      n_chk++;
      if (acc !== 64) $display("FAIL load_count: got %0d want 64", acc);
      else n_pass++;
      n_chk++;
      if (low_k !== 64) $display("FAIL load_ready_drop: got cycle %0d want 64", low_k);
      else n_pass++;
      n_chk++;
      if (ld_full !== 1'b1) $display("FAIL load_full: got %b want 1", ld_full);
      else n_pass++;
   endtask

   task automatic test_commit_swap();
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      n_chk++;
      if ({commit_pend, active_bank, commit_ack} !== 3'b100)
         $display("FAIL pend_hold: got pend,bank,ack=%b want 100", {commit_pend, active_bank, commit_ack});
      else n_pass++;
      read_a(6'd0);
      n_chk++;
      if (rd_data !== 16'hB000) $display("FAIL pend_read_old: got %h want b000", rd_data);
      else n_pass++;
      swap_ok = 1'b1;
      rd_en = 1'b1;
      rd_addr = 6'd5;
      tick();
      swap_ok = 1'b0;
      n_chk++;
      if ({active_bank, commit_ack, commit_pend} !== 3'b110)
         $display("FAIL swap_flags: got bank,ack,pend=%b want 110", {active_bank, commit_ack, commit_pend});
      else n_pass++;
      n_chk++;
      if (rd_data !== 16'hB005) $display("FAIL swap_cycle_read: got %h want b005", rd_data);
      else n_pass++;
      tick();
      rd_en = 1'b0;
      n_chk++;
      if (rd_data !== 16'h0006) $display("FAIL post_swap_read: got %h want 0006", rd_data);
      else n_pass++;
      n_chk++;
      if ({commit_ack, ld_full} !== 2'b00)
         $display("FAIL ack_pulse: got ack,full=%b want 00", {commit_ack, ld_full});
      else n_pass++;
      read_a(6'd0);
      n_chk++;
      if (rd_data !== 16'h0001) $display("FAIL new_bank_addr0: got %h want 0001", rd_data);
      else n_pass++;
      read_a(6'd63);
      n_chk++;
      if (rd_data !== 16'h0040) $display("FAIL new_bank_addr63: got %h want 0040", rd_data);
      else n_pass++;
   endtask

   task automatic test_error_abort();
      start_a();
      load_a(16'hC000, 0, 10);
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      n_chk++;
      if ({commit_err, commit_pend, ld_ready} !== 3'b101)
         $display("FAIL early_commit: got err,pend,ready=%b want 101", {commit_err, commit_pend, ld_ready});
      else n_pass++;
      tick();
      n_chk++;
      if (commit_err !== 1'b0) $display("FAIL err_pulse: got %b want 0", commit_err);
      else n_pass++;
      load_a(16'hC000, 10, 54);
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      n_chk++;
      if ({commit_pend, ld_full} !== 2'b11)
         $display("FAIL abort_pend: got pend,full=%b want 11", {commit_pend, ld_full});
      else n_pass++;
      start_a();
      n_chk++;
      if ({commit_pend, ld_full, ld_ready} !== 3'b001)
         $display("FAIL abort_clear: got pend,full,ready=%b want 001", {commit_pend, ld_full, ld_ready});
      else n_pass++;
      swap_ok = 1'b1;
      tick();
      tick();
      swap_ok = 1'b0;
      n_chk++;
      if ({active_bank, commit_ack} !== 2'b10)
         $display("FAIL abort_no_swap: got bank,ack=%b want 10", {active_bank, commit_ack});
      else n_pass++;
   endtask

   task automatic test_boundary40();
      int acc = 0;
      int k = 0;
      b_ld_start = 1'b1;
      tick();
      b_ld_start = 1'b0;
      while (!b_ld_full && k < 200) begin
         b_ld_valid = (k % 2 == 0);
         b_ld_data  = 16'h2000 + 16'(acc);
         if (b_ld_valid && b_ld_ready) acc++;
         tick();
         k++;
      end
      b_ld_valid = 1'b1;
      b_ld_data  = 16'hDEAD;
      tick();
      b_ld_valid = 1'b0;
      n_chk++;
      if (acc !== 40 || b_ld_full !== 1'b1 || b_ld_ready !== 1'b0)
         $display("FAIL b40_load: got count=%0d full=%b ready=%b want 40 1 0", acc, b_ld_full, b_ld_ready);
      else n_pass++;
      b_commit_req = 1'b1;
      tick();
      b_commit_req = 1'b0;
      b_swap_ok = 1'b1;
      tick();
      b_swap_ok = 1'b0;
      n_chk++;
      if (b_active_bank !== 1'b1) $display("FAIL b40_swap: got %b want 1", b_active_bank);
      else n_pass++;
      read_b(6'd0);
      n_chk++;
      if (b_rd_data !== 16'h2000) $display("FAIL b40_addr0: got %h want 2000", b_rd_data);
      else n_pass++;
      read_b(6'd17);
      n_chk++;
      if (b_rd_data !== 16'h2011) $display("FAIL b40_addr17: got %h want 2011", b_rd_data);
      else n_pass++;
      read_b(6'd39);
      n_chk++;
      if (b_rd_data !== 16'h2027) $display("FAIL b40_addr39: got %h want 2027", b_rd_data);
      else n_pass++;
      read_b(6'd45);
      n_chk++;
      if (b_rd_data !== 16'h0000) $display("FAIL b40_oob: got %h want 0000", b_rd_data);
      else n_pass++;
      tick();
      n_chk++;
      if (b_rd_data !== 16'h0000) $display("FAIL b40_hold: got %h want 0000", b_rd_data);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      start_a();
      load_a(16'hD000, 0, 64);
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      n_chk++;
      if (commit_pend !== 1'b1) $display("FAIL rmid_pend: got %b want 1", commit_pend);
      else n_pass++;
      rst_n = 1'b0;
      swap_ok = 1'b1;
      tick();
      n_chk++;
      if ({ld_ready, ld_full, commit_pend, commit_ack, commit_err, active_bank} !== 6'b0)
         $display("FAIL rmid_flags: got %b want 000000",
                  {ld_ready, ld_full, commit_pend, commit_ack, commit_err, active_bank});
      else n_pass++;
      rst_n = 1'b1;
      tick();
      swap_ok = 1'b0;
      n_chk++;
      if ({active_bank, commit_ack} !== 2'b00)
         $display("FAIL rmid_no_swap: got bank,ack=%b want 00", {active_bank, commit_ack});
      else n_pass++;
      read_a(6'd3);
      n_chk++;
      if (rd_data !== 16'hD003) $display("FAIL rmid_mem_kept: got %h want d003", rd_data);
      else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      ld_start = 0; ld_valid = 0; commit_req = 0; swap_ok = 0; rd_en = 0;
      ld_data = '0; rd_addr = '0;
      b_ld_start = 0; b_ld_valid = 0; b_commit_req = 0; b_swap_ok = 0; b_rd_en = 0;
      b_ld_data = '0; b_rd_addr = '0;
      test_reset();
      test_preload();
      test_load();
      test_commit_swap();
      test_error_abort();
      test_boundary40();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cmem_dbuf.md
Name: cmem_dbuf

Overview:
Parametrised, double-buffered coefficient memory for the FIR filter datapath. It holds two banks of TAPS coefficients. The filter reads the active bank while the host streams a new coefficient set into the shadow bank. After commit, the banks swap atomically at a filter-signalled safe point, so coefficient sets can be updated without glitching an in-flight convolution.

Parameters:
DATA_W, 16, coefficient width in bits
TAPS, 64, coefficients per bank (2..1024; need not be a power of 2)
ADDR_W, 6, read address width; must equal ceil(log2(TAPS))

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-low
ld_start  in  1  pulse; restart shadow load at index 0
ld_valid  in  1  load data valid
ld_ready  out  1  shadow bank accepts a word
ld_data  in  DATA_W  coefficient to load
ld_full  out  1  shadow bank holds a complete set of TAPS words
commit_req  in  1  pulse; request bank swap
commit_pend  out  1  swap armed, waiting for swap_ok
commit_ack  out  1  one-cycle pulse in the cycle after the swap takes effect
commit_err  out  1  one-cycle pulse; commit_req rejected
swap_ok  in  1  filter at a frame boundary; a swap is safe this cycle
rd_en  in  1  read enable
rd_addr  in  ADDR_W  tap index to read from the active bank
rd_data  out  DATA_W  registered coefficient
active_bank  out  1  index of the bank currently read by the filter

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; active_bank=0.
  - ld_ready, ld_full, commit_pend, commit_ack, commit_err all 0.
  - rd_data=0; load pointer wptr=0.
  - Memory contents are not cleared.
  - Reset mid-load or mid-pending abandons the operation. No swap occurs.
- States:
  - IDLE: ld_ready=0.
  - LOAD: ld_ready=1.
  - FULL: ld_full=1.
  - PEND: ld_full=1, commit_pend=1.
- ld_start, in any state: wptr<=0, state<=LOAD next cycle. This discards any partial or full shadow set and cancels a pending commit.
- LOAD: each cycle with ld_valid&&ld_ready writes ld_data to shadow[wptr] and increments wptr.
  - The write at wptr==TAPS-1 moves the state to FULL. ld_ready drops in the following cycle, so exactly TAPS words are accepted.
  - ld_valid with ld_ready=0 is ignored; no write occurs.
- ld_start and ld_valid in the same cycle: ld_start wins and the data word is dropped.
- commit_req:
  - In FULL: state<=PEND.
  - In IDLE or LOAD: commit_err pulses the next cycle; the state is unchanged.
  - In PEND: ignored, no error.
- PEND with swap_ok=1 at a clk edge:
  - active_bank toggles; state<=IDLE; wptr<=0.
  - commit_ack=1 for the following cycle.
  - commit_req and swap_ok in the same cycle while in FULL: the state goes to PEND only. The swap needs swap_ok in a later cycle.
- Read port: 1-cycle latency.
  - rd_en=1 at edge N: rd_data at N+1 = active[rd_addr], using active_bank as it was before edge N.
  - A read issued in the swap cycle returns the old bank. Reads from the next cycle onward return the new bank.
  - rd_en=0: rd_data holds its previous value.
  - rd_addr>=TAPS: rd_data<=0.
- The read bank and the write bank always differ, so no read/write collision is possible.
- Storage: 2*TAPS words of DATA_W. Inferred as a single SRAM with bank bit {bank, index}, or as two arrays. 1 write port and 1 read port.

Test Plan:
- Reset then load: ld_start, stream 64 words 0x0001..0x0040 with ld_valid held high -> exactly 64 accepted; ld_ready low from the 65th cycle; ld_full=1.
- Commit/swap: after the load, commit_req; hold swap_ok=0 for 5 cycles -> commit_pend=1 and no swap; read addr 0 returns old bank data. Then swap_ok=1 -> active_bank 0->1 and commit_ack pulses; read addr 0 returns 0x0001 and addr 63 returns 0x0040.
- Swap-cycle read: rd_en with addr 5 in the swap edge cycle -> old-bank value. Same read one cycle later -> 0x0006.
- Error/abort: commit_req after 10 loaded words -> commit_err pulse, no pend. ld_start while in PEND -> commit_pend clears; swap_ok then causes no swap.
- Boundaries: TAPS=40, ADDR_W=6: rd_addr=45 -> rd_data=0. Backpressure with ld_valid toggling every other cycle -> all 40 words land at the correct indices.
- Reset mid-operation: rst_n low during PEND with swap_ok=1 -> active_bank stays 0; all flags 0 after the edge.
